playfield: RTL and testbench

Parametrised Tetris playfield store: a ROWS × COLS array of CELL_W-bit cells, with row-addressed read/write ports. It also has a built-in line-clear engine. On request, the engine scans every row from bottom to top, removes each completely filled row, collapses the rows above it down by one, and reports how many lines were removed. It sits between the game-logic controller, which writes locked pieces and triggers clears, and the display/collision logic, which reads rows.

---
 rtl/playfield_if.sv | 41 ++++
 rtl/playfield.sv | 140 ++++++++++++++
 tb/tb_playfield.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/playfield_if.sv
// -----------------------------------------------------------------------------
// playfield_if
// Bus between the game-logic controller (master) and the playfield store
// (slave).
//   wnr           : 1 = write `in` to row `rowid` this cycle, 0 = read
//   rowid         : row address, row 0 is the bottom of the board
//   in            : write data, cell c at bits [c*CELL_W +: CELL_W]
//   out           : registered read data (1-cycle latency)
//   clear_start   : single-cycle request to run the line-clear engine
//   busy          : clear engine active
//   clear_done    : one-cycle pulse in the last busy cycle
//   lines_cleared : rows removed by the last completed clear
// -----------------------------------------------------------------------------
interface playfield_if #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 2
);
    localparam int ROW_W = COLS * CELL_W;
    localparam int RID_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);

    logic             wnr;
    logic [RID_W-1:0] rowid;
    logic [ROW_W-1:0] in;
    logic [ROW_W-1:0] out;
    logic             clear_start;
    logic             busy;
    logic             clear_done;
    logic [CNT_W-1:0] lines_cleared;

    modport master (
        output wnr, rowid, in, clear_start,
        input  out, busy, clear_done, lines_cleared
    );

    modport slave (
        input  wnr, rowid, in, clear_start,
        output out, busy, clear_done, lines_cleared
    );
endinterface

// File: rtl/playfield.sv
// -----------------------------------------------------------------------------
// playfield
// ROWS x COLS board of CELL_W-bit cells (0 = empty) with a row-addressed
// read/write port and a line-clear engine. On clear_start the engine walks the
// rows bottom to top, one row per cycle; a full row is removed by moving every
// row above it down by one in a single cycle, and the same position is checked
// again. The number of removed rows is reported with clear_done.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : playfield_if.slave (row port, clear request, status)
// -----------------------------------------------------------------------------
module playfield #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 2
) (
    input logic        clk,
    input logic        reset_n,
    playfield_if.slave bus
);
    localparam int ROW_W = COLS * CELL_W;
    localparam int RID_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);

    // ROWS always fits in RID_W+1 bits, so the range check never truncates.
    localparam logic [RID_W:0]   ROW_LIMIT = (RID_W + 1)'(ROWS);
    localparam logic [RID_W-1:0] LAST_ROW  = RID_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [RID_W-1:0] r, r_next;
    logic [CNT_W-1:0] count, count_next;
    logic [ROW_W-1:0] mem [ROWS];
    logic             row_full;
    logic             collapse;
    logic             rowid_ok;
    logic             wr_en;

    assign rowid_ok = {1'b0, bus.rowid} < ROW_LIMIT;

    // The controller may only modify the board while the engine is idle.
    assign wr_en = bus.wnr && rowid_ok && (state == IDLE);

    // A row is full when no cell is zero.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (mem[r][c*CELL_W +: CELL_W] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        r_next     = r;
        count_next = count;
        collapse   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_start) begin
                    state_next = SCAN;
                    r_next     = '0;
                    count_next = '0;
                end
            end
            SCAN: begin
                if (row_full) begin
                    // r holds: the row that drops into position r is checked next.
                    collapse   = 1'b1;
                    count_next = count + 1'b1;
                end else if (r == LAST_ROW) begin
                    state_next = DONE;
                end else begin
                    r_next = r + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            r                 <= '0;
            count             <= '0;
            bus.busy          <= 1'b0;
            bus.clear_done    <= 1'b0;
            bus.lines_cleared <= '0;
        end else begin
            state          <= state_next;
            r              <= r_next;
            count          <= count_next;
            bus.busy       <= (state_next != IDLE);
            bus.clear_done <= (state_next == DONE);
            // Loaded on entry to DONE so the count is valid alongside clear_done.
            if (state == SCAN && state_next == DONE) begin
                bus.lines_cleared <= count_next;
            end
        end
    end

    // NOTE: the board is a register array, not a RAM macro, and must read as
    // empty after reset, so every row is cleared by the reset branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
            bus.out <= '0;
        end else begin
            // Read-before-write: out always shows the contents before this edge.
            bus.out <= rowid_ok ? mem[bus.rowid] : '0;
            if (collapse) begin
                for (int i = 0; i < ROWS - 1; i++) begin
                    if (RID_W'(i) >= r) begin
                        mem[i] <= mem[i+1];
                    end
                end
                mem[ROWS-1] <= '0;
            end else if (wr_en) begin
                mem[bus.rowid] <= bus.in;
            end
        end
    end
endmodule

// File: tb/tb_playfield.sv
// -----------------------------------------------------------------------------
// tb_playfield
// Self-checking bench for playfield (ROWS=20, COLS=10, CELL_W=2). Expected
// board contents come from a reference model that clears lines by keeping the
// non-full rows in order and padding the top with empty rows.
// -----------------------------------------------------------------------------
module tb_playfield;
    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 2;
    localparam int ROW_W  = COLS * CELL_W;
    localparam int RID_W  = $clog2(ROWS);

    typedef struct {
        logic             wnr;
        logic [RID_W-1:0] rowid;
        logic [ROW_W-1:0] din;
        logic [ROW_W-1:0] exp_out;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [ROW_W-1:0] model_mem [ROWS];

    playfield_if #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) bus ();

    playfield #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_full(input logic [ROW_W-1:0] row);
        for (int c = 0; c < COLS; c++) begin
            if (row[c*CELL_W +: CELL_W] == '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Surviving rows keep their order and fall to the bottom; returns rows removed.
    function automatic int model_clear();
        logic [ROW_W-1:0] kept [$];
        for (int i = 0; i < ROWS; i++) begin
            if (!is_full(model_mem[i])) kept.push_back(model_mem[i]);
        end
        for (int i = 0; i < ROWS; i++) begin
            model_mem[i] = (i < kept.size()) ? kept[i] : '0;
        end
        return ROWS - kept.size();
    endfunction

    task automatic model_zero();
        for (int i = 0; i < ROWS; i++) model_mem[i] = '0;
    endtask

    task automatic write_row(input int row, input logic [ROW_W-1:0] value);
        bus.wnr   = 1'b1;
        bus.rowid = RID_W'(row);
        bus.in    = value;
        tick();
        bus.wnr   = 1'b0;
    endtask

    task automatic load_board();
        for (int i = 0; i < ROWS; i++) write_row(i, model_mem[i]);
    endtask

    task automatic read_all(input string name);
        bus.wnr = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            bus.rowid = RID_W'(i);
            tick();
            check($sformatf("%s row%0d", name, i), bus.out, model_mem[i]);
        end
    endtask

    // Runs one clear; with inject set, a write and a second clear_start are
    // issued while the engine is busy and must both be ignored.
    task automatic run_clear(input string name, input bit inject);
        int exp_k;
        int exp_cycles;
        int busy_cycles;
        int done_pulses;
        int done_at;
        exp_k       = model_clear();
        exp_cycles  = ROWS + exp_k + 1;
        bus.wnr     = 1'b0;
        bus.rowid   = '0;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        busy_cycles = 0;
        done_pulses = 0;
        done_at     = 0;
        while (bus.busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            if (bus.clear_done === 1'b1) begin
                done_pulses++;
                done_at = busy_cycles;
                check({name, " lines_at_done"}, bus.lines_cleared, exp_k);
            end
            if (inject && busy_cycles == 3) begin
                bus.wnr = 1'b1;
                bus.in  = '1;
            end
            if (inject && busy_cycles == 5) bus.clear_start = 1'b1;
            tick();
            bus.wnr         = 1'b0;
            bus.clear_start = 1'b0;
        end
        check({name, " busy_cycles"}, busy_cycles, exp_cycles);
        check({name, " done_pulses"}, done_pulses, 1);
        check({name, " done_in_last_busy"}, done_at, exp_cycles);
        check({name, " lines_cleared"}, bus.lines_cleared, exp_k);
        check({name, " done_low_after"}, bus.clear_done, 0);
        read_all(name);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.clear_done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        check({name, " quiet"}, pulses, 0);
    endtask

    initial begin
        vec_t vecs [60];
        logic [RID_W-1:0] rid;
        logic [ROW_W-1:0] exp;
        logic [ROW_W-1:0] row;

        for (int i = 0; i < 30; i++) begin
            vecs[i]      = '{wnr: 1'b1, rowid: RID_W'(i), din: ROW_W'(i), exp_out: '0};
            vecs[30 + i] = '{wnr: 1'b0, rowid: RID_W'(i), din: '0,
                             exp_out: (i < ROWS) ? ROW_W'(i) : '0};
        end

        bus.wnr = 1'b0;
        bus.rowid = '0;
        bus.in = '0;
        bus.clear_start = 1'b0;
        model_zero();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset busy", bus.busy, 0);
        check("reset clear_done", bus.clear_done, 0);
        check("reset lines_cleared", bus.lines_cleared, 0);
        check("reset out", bus.out, 0);
        read_all("reset");

        // Table: writes to rows 0..29 (old data returned), then read back
        for (int i = 0; i < 60; i++) begin
            bus.wnr   = vecs[i].wnr;
            bus.rowid = vecs[i].rowid;
            bus.in    = vecs[i].din;
            tick();
            check($sformatf("vec%0d rowid%0d", i, vecs[i].rowid), bus.out, vecs[i].exp_out);
        end
        bus.wnr = 1'b0;
        for (int i = 0; i < ROWS; i++) model_mem[i] = ROW_W'(i);

        // One full row with a partial row above it
        model_zero();
        model_mem[3] = 20'hFFFFF;
        model_mem[4] = 20'h00001;
        load_board();
        run_clear("one_line", 1'b0);

        // Four stacked full rows
        model_zero();
        for (int i = 0; i < 4; i++) model_mem[i] = 20'h55555;
        model_mem[4] = 20'h00003;
        load_board();
        run_clear("four_lines", 1'b0);

        // Top row only, with a write and a second request while busy
        model_zero();
        model_mem[19] = 20'hAAAAA;
        load_board();
        run_clear("top_row", 1'b1);
        watch_quiet("top_row", 30);

        // Asynchronous reset five cycles into a scan
        model_zero();
        for (int i = 0; i < 4; i++) model_mem[i] = 20'h55555;
        model_mem[5] = 20'h12345;
        load_board();
        bus.rowid = 5'd5;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        repeat (4) tick();
        check("midscan busy", bus.busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midscan_rst busy", bus.busy, 0);
        check("midscan_rst clear_done", bus.clear_done, 0);
        check("midscan_rst lines_cleared", bus.lines_cleared, 0);
        check("midscan_rst out", bus.out, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_zero();
        watch_quiet("midscan_rst", 30);
        check("midscan_rst lines_hold", bus.lines_cleared, 0);
        read_all("midscan_rst");

        // Random reads and writes against the model, including out-of-range rows
        for (int n = 0; n < 200; n++) begin
            rid       = RID_W'($urandom_range(0, 25));
            bus.wnr   = 1'($urandom_range(0, 1));
            bus.rowid = rid;
            bus.in    = ROW_W'($urandom);
            exp       = (rid < ROWS) ? model_mem[rid] : '0;
            tick();
            check($sformatf("rand_rw%0d rowid%0d", n, rid), bus.out, exp);
            if (bus.wnr && rid < ROWS) model_mem[rid] = bus.in;
        end
        bus.wnr = 1'b0;

        // Random boards with a mix of full and partial rows
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < ROWS; i++) begin
                if ($urandom_range(0, 9) < 4) begin
                    for (int c = 0; c < COLS; c++) row[c*CELL_W +: CELL_W] = 2'($urandom_range(1, 3));
                end else begin
                    row = ROW_W'($urandom);
                end
                model_mem[i] = row;
            end
            load_board();
            run_clear($sformatf("rand_clear%0d", round), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
